// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display bank: segment type,
// blank pattern, the active-low hex encode table and sequencer states.
package hex_display_pkg;

    // One 7-segment digit, bit0 = a .. bit6 = g, 0 = segment lit.
    typedef logic [6:0] seg_t;

    // All segments off.
    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low glyphs for 0..F (b and d are lower case).
    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Serial update sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_COMMIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/hex_seg_encoder.sv
// Combinational hex nibble to active-low 7-segment lookup. A single copy
// is time-shared across all digits by the serial sequencer.
module hex_seg_encoder
    import hex_display_pkg::*;
(
    input  logic [3:0] digit,
    output seg_t       seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit 7-segment driver. A load captures a packed hex value, the
// digits are encoded one per cycle (MSD first) into a frame buffer, and
// the finished frame is committed to the outputs in one cycle so the
// display never shows a half-updated value. Supports leading-zero blanking
// and per-digit blinking.
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] segs,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BLINK_DIV + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    seq_state_t              state_reg, state_next;
    logic                    accept, encode_step, commit;

    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic                    seen_nz_reg;
    logic                    done_reg;
    seg_t                    frame_reg     [NUM_DIGITS];
    seg_t                    committed_reg [NUM_DIGITS];

    logic [3:0]              cur_digit;
    seg_t                    enc_seg;
    logic                    blank_digit;

    logic [CNT_W-1:0]        blink_cnt_reg, blink_cnt_next;
    logic                    phase_reg, phase_next;

    seg_t                    digit_src [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] segs_reg, segs_next;

    // Digit currently being encoded comes from the captured copy, never
    // from the live input, so value_in may change freely while busy.
    assign cur_digit = shadow_reg[{idx_reg, 2'b00} +: 4];

    hex_seg_encoder u_enc (
        .digit (cur_digit),
        .seg   (enc_seg)
    );

    // Leading zeros are blanked until the first non-zero digit; the least
    // significant digit is always shown so a zero value reads "0".
    assign blank_digit = LZ_BLANK && !seen_nz_reg && (cur_digit == 4'd0) && (idx_reg != '0);

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sequencer next state and step strobes.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        encode_step = 1'b0;
        commit      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    accept     = 1'b1;
                    state_next = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                encode_step = 1'b1;
                if (idx_reg == '0) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture, serial encode into the frame buffer, and whole-frame commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg  <= '0;
            idx_reg     <= '0;
            seen_nz_reg <= 1'b0;
            done_reg    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                frame_reg[i]     <= SEG_BLANK;
                committed_reg[i] <= SEG_BLANK;
            end
        end else begin
            done_reg <= commit;
            if (accept) begin
                shadow_reg  <= value_in;
                idx_reg     <= IDX_LAST;
                seen_nz_reg <= 1'b0;
            end
            if (encode_step) begin
                frame_reg[idx_reg] <= blank_digit ? SEG_BLANK : enc_seg;
                if (cur_digit != 4'd0) begin
                    seen_nz_reg <= 1'b1;
                end
                if (idx_reg != '0) begin
                    idx_reg <= idx_reg - 1'b1;
                end
            end
            if (commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    committed_reg[i] <= frame_reg[i];
                end
            end
        end
    end

    // Blink divider: free-runs only while enabled, phase flips on each wrap.
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        phase_next     = phase_reg;
        if (!blink_en) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_cnt_reg == CNT_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
        end
    end

    // Output digits are built from the values the registers are about to
    // hold, so a commit and a phase change reach segs on the same edge.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_src[gi]          = commit ? frame_reg[gi] : committed_reg[gi];
        assign segs_next[7*gi +: 7]   = (blink_en && phase_next && blink_mask[gi])
                                        ? SEG_BLANK : digit_src[gi];
    end

    // Blink state and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            segs_reg      <= '1;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            segs_reg      <= segs_next;
        end
    end

    assign segs = segs_reg;
    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;

endmodule
